// File: rtl/mux_2to1_rr_arbiter.sv
// mux_2to1_rr_arbiter
// Two-channel round-robin arbiter feeding a 2:1 mux stage. Accepts two
// valid/ready streams, registers the winning word in a single-entry output
// stage and drives the mux select (s) and enable from that stage.
// Priority rotates only on an actual transfer, so stalls never skew fairness.

module mux_2to1_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             s,
  output logic             enable
);

  // Output register occupancy states
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Round-robin pick: returns {grant_any, grant_idx}.
  // With both channels requesting, the channel that did not win last time wins.
  function automatic logic [1:0] rr_pick(
    input logic v0,
    input logic v1,
    input logic last
  );
    logic [1:0] res;
    case ({v1, v0})
      2'b01:   res = 2'b10;
      2'b10:   res = 2'b11;
      2'b11:   res = {1'b1, ~last};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // Registered state
  logic [0:0]       state_q,      state_d;
  logic [WIDTH-1:0] out_data_q,   out_data_d;
  logic             s_q,          s_d;
  logic             last_grant_q, last_grant_d;

  // Combinational arbitration signals
  logic             grant_any;
  logic             grant_idx;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;

  // Arbitration: who wins, whether the output stage can take a word, and the winning payload
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = 1'b0;
    load       = 1'b0;
    xfer       = 1'b0;
    grant_data = {WIDTH{1'b0}};
    {grant_any, grant_idx} = rr_pick(in0_valid, in1_valid, last_grant_q);
    // The stage can load when it is empty or its current word leaves this cycle
    load = (state_q == ST_EMPTY) | out_ready;
    xfer = load & grant_any;
    if (grant_idx) begin
      grant_data = in1_data;
    end else begin
      grant_data = in0_data;
    end
  end

  // Input handshakes; held low while reset is asserted so nothing is accepted
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (rst_n) begin
      in0_ready = xfer & in0_valid & ~grant_idx;
      in1_ready = xfer & in1_valid &  grant_idx;
    end else begin
      in0_ready = 1'b0;
      in1_ready = 1'b0;
    end
  end

  // Next-state for the single-entry output stage and the priority pointer
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    s_d          = s_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_EMPTY: begin
        if (grant_any) begin
          state_d      = ST_FULL;
          out_data_d   = grant_data;
          s_d          = grant_idx;
          last_grant_d = grant_idx;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (grant_any) begin
            // Pass-through: current word leaves and the winner replaces it in the same edge
            state_d      = ST_FULL;
            out_data_d   = grant_data;
            s_d          = grant_idx;
            last_grant_d = grant_idx;
          end else begin
            // Word consumed, nothing to replace it; data/select simply hold
            state_d = ST_EMPTY;
          end
        end else begin
          // Downstream stalled: hold everything, priority does not rotate
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d      = ST_EMPTY;
        out_data_d   = {WIDTH{1'b0}};
        s_d          = 1'b0;
        last_grant_d = 1'b1;
      end
    endcase
  end

  // State registers; last_grant resets to 1 so channel 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= {WIDTH{1'b0}};
      s_q          <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      s_q          <= s_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output drive straight from the registers
  always_comb begin
    out_data  = out_data_q;
    out_valid = (state_q == ST_FULL);
    enable    = (state_q == ST_FULL);
    s         = s_q;
  end

endmodule
